// File: rtl/ballot_if.sv
// Voter-booth signal bundle between the polling officer/buttons side and the ballot unit.
interface ballot_if;
  logic       enable_ballot;
  logic [3:0] btn;
  logic       v1;
  logic       v2;
  logic       v3;
  logic       v4;
  logic       ready;
  logic       busy;
  logic [7:0] voter_count;
  logic       timeout_flag;

  modport master (
    output enable_ballot, btn,
    input  v1, v2, v3, v4, ready, busy, voter_count, timeout_flag
  );

  modport slave (
    input  enable_ballot, btn,
    output v1, v2, v3, v4, ready, busy, voter_count, timeout_flag
  );
endinterface

// File: rtl/ballot_unit.sv
// Electronic ballot unit: synchronizes and debounces four voter buttons and
// emits exactly one vote pulse per officer-released ballot.
module ballot_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic     clk,
  input  logic     reset,
  ballot_if.slave  bus_io
);

  localparam int unsigned NB = 4;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned CW = 8;

  localparam logic [1:0] S_LOCKED = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] deb_q, deb_d;
  logic [NB-1:0] deb_prev_q;
  logic [NB-1:0] press_q;
  logic [NB-1:0] mask_q, mask_d;
  logic [DW-1:0] dcnt_q [NB];
  logic [DW-1:0] dcnt_d [NB];
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    state_q, state_d;
  logic [NB-1:0] v_q, v_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          flag_q, flag_d;
  logic [CW-1:0] count_q, count_d;

  logic [NB-1:0] held_c;
  logic [NB-1:0] valid_c;
  logic          onehot_c;

  // Per-bit debounce: the level flips only after an unbroken run of mismatches.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NB; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Buttons already held when the ballot opens stay masked until released.
  always_comb begin
    held_c   = deb_q | sync2_q;
    mask_d   = (state_q == S_LOCKED) ? held_c : (mask_q & held_c);
    valid_c  = press_q & ~mask_q;
    onehot_c = (valid_c != '0) && ((valid_c & (valid_c - NB'(1))) == '0);
  end

  // Ballot FSM next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    count_d = count_q;
    v_d     = '0;
    flag_d  = 1'b0;
    case (state_q)
      S_LOCKED: begin
        tcnt_d = '0;
        if (bus_io.enable_ballot) state_d = S_ARMED;
      end
      S_ARMED: begin
        tcnt_d = tcnt_q + TW'(1);
        if (onehot_c) begin
          state_d = S_EMIT;
          v_d     = valid_c;
          count_d = (count_q == CW'(255)) ? count_q : count_q + CW'(1);
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_LOCKED;
          flag_d  = 1'b1;
        end
      end
      S_EMIT: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (deb_q == '0) state_d = S_LOCKED;
      end
      default: begin
        state_d = S_LOCKED;
      end
    endcase
    ready_d = (state_d == S_ARMED);
    busy_d  = (state_d == S_EMIT) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      mask_q     <= '0;
      dcnt_q     <= '{default: '0};
      tcnt_q     <= '0;
      state_q    <= S_LOCKED;
      v_q        <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      flag_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      sync1_q    <= bus_io.btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      mask_q     <= mask_d;
      dcnt_q     <= dcnt_d;
      tcnt_q     <= tcnt_d;
      state_q    <= state_d;
      v_q        <= v_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      flag_q     <= flag_d;
      count_q    <= count_d;
    end
  end

  assign bus_io.v1           = v_q[0];
  assign bus_io.v2           = v_q[1];
  assign bus_io.v3           = v_q[2];
  assign bus_io.v4           = v_q[3];
  assign bus_io.ready        = ready_q;
  assign bus_io.busy         = busy_q;
  assign bus_io.timeout_flag = flag_q;
  assign bus_io.voter_count  = count_q;

endmodule

// File: tb/tb_ballot_unit.sv
// Directed self-checking bench for ballot_unit with hand-computed expectations.
module tb_ballot_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ballot_if bif ();

  ballot_unit #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bif)
  );

  int tests = 0;
  int fails = 0;
  int exp_count;
  int p;
  int total;
  int nb;
  logic [3:0] s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] vout();
    return {bif.v4, bif.v3, bif.v2, bif.v1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic watch(input int n, output int pulses, output logic [3:0] seen);
    pulses = 0;
    seen   = '0;
    repeat (n) begin
      tick();
      if (vout() != 4'b0000) pulses++;
      seen |= vout();
    end
  endtask

  task automatic enable_pulse();
    bif.enable_ballot = 1'b1;
    tick();
    bif.enable_ballot = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bif.btn = 4'b0000;
    bif.enable_ballot = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(bif.ready), 0);
    chk("rst_busy",  32'(bif.busy), 0);
    chk("rst_v",     32'(vout()), 0);
    chk("rst_flag",  32'(bif.timeout_flag), 0);
    chk("rst_count", 32'(bif.voter_count), 0);
    reset = 1'b0;
    tick();
    exp_count = 0;

    // Single press: exact latency and one-cycle pulse
    enable_pulse();
    chk("t1_ready", 32'(bif.ready), 1);
    bif.btn = 4'b0001;
    p = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (vout() != 4'b0000) p++;
    end
    chk("t1_no_early_vote", 32'(p), 0);
    chk("t1_ready_hold", 32'(bif.ready), 1);
    tick();
    exp_count = 1;
    chk("t1_v1_pulse", 32'(vout()), 32'h1);
    chk("t1_count", 32'(bif.voter_count), 32'(exp_count));
    chk("t1_busy_emit", 32'(bif.busy), 1);
    chk("t1_ready_emit", 32'(bif.ready), 0);
    tick();
    chk("t1_v1_off", 32'(vout()), 0);
    chk("t1_busy_wait", 32'(bif.busy), 1);
    watch(3, p, s);
    bif.btn = 4'b0000;
    watch(10, p, s);
    chk("t1_release_quiet", 32'(p), 0);
    chk("t1_locked_busy", 32'(bif.busy), 0);
    chk("t1_locked_ready", 32'(bif.ready), 0);

    // Two simultaneous presses are ignored, then a single press votes
    enable_pulse();
    bif.btn = 4'b0110;
    watch(12, p, s);
    chk("t2_multi_no_vote", 32'(p), 0);
    chk("t2_multi_ready", 32'(bif.ready), 1);
    bif.btn = 4'b0000;
    watch(10, p, s);
    chk("t2_multi_release", 32'(p), 0);
    bif.btn = 4'b1000;
    watch(12, p, s);
    exp_count++;
    chk("t2_v4_pulses", 32'(p), 1);
    chk("t2_v4_which", 32'(s), 32'h8);
    chk("t2_count", 32'(bif.voter_count), 32'(exp_count));
    bif.btn = 4'b0000;
    watch(10, p, s);
    chk("t2_locked", 32'(bif.busy), 0);

    // Bouncing button never debounces; a steady press then votes once
    enable_pulse();
    p = 0;
    for (int i = 0; i < 10; i++) begin
      bif.btn[1] = ~bif.btn[1];
      tick();
      if (vout() != 4'b0000) p++;
      tick();
      if (vout() != 4'b0000) p++;
    end
    chk("t3_bounce_no_vote", 32'(p), 0);
    chk("t3_bounce_ready", 32'(bif.ready), 1);
    bif.btn = 4'b0010;
    watch(12, p, s);
    exp_count++;
    chk("t3_v2_pulses", 32'(p), 1);
    chk("t3_v2_which", 32'(s), 32'h2);
    chk("t3_count", 32'(bif.voter_count), 32'(exp_count));
    bif.btn = 4'b0000;
    watch(10, p, s);

    // Unused ballot times out after exactly 1000 armed cycles
    enable_pulse();
    p = 0;
    repeat (999) begin
      tick();
      if (bif.timeout_flag) p++;
    end
    chk("t4_no_early_flag", 32'(p), 0);
    chk("t4_ready_before", 32'(bif.ready), 1);
    tick();
    chk("t4_flag", 32'(bif.timeout_flag), 1);
    chk("t4_ready_after", 32'(bif.ready), 0);
    tick();
    chk("t4_flag_off", 32'(bif.timeout_flag), 0);
    bif.btn = 4'b0100;
    watch(12, p, s);
    chk("t4_late_press", 32'(p), 0);
    chk("t4_count", 32'(bif.voter_count), 32'(exp_count));
    bif.btn = 4'b0000;
    watch(10, p, s);

    // Button held before arming must be released and re-pressed
    bif.btn = 4'b0001;
    watch(10, p, s);
    chk("t5_locked_press", 32'(p), 0);
    enable_pulse();
    chk("t5_ready", 32'(bif.ready), 1);
    watch(15, p, s);
    chk("t5_held_no_vote", 32'(p), 0);
    chk("t5_still_ready", 32'(bif.ready), 1);
    bif.btn = 4'b0000;
    watch(10, p, s);
    chk("t5_release", 32'(p), 0);
    bif.btn = 4'b0001;
    watch(12, p, s);
    exp_count++;
    chk("t5_repress_pulses", 32'(p), 1);
    chk("t5_repress_which", 32'(s), 32'h1);
    chk("t5_count", 32'(bif.voter_count), 32'(exp_count));
    enable_pulse();
    chk("t5_enable_ignored", 32'(bif.ready), 0);
    chk("t5_busy_held", 32'(bif.busy), 1);
    watch(15, p, s);
    chk("t5_no_second_vote", 32'(p), 0);
    bif.btn = 4'b0000;
    watch(10, p, s);
    chk("t5_locked", 32'(bif.busy), 0);

    // Saturation of the ballot counter
    nb = 255 - exp_count + 2;
    total = 0;
    for (int b = 0; b < nb; b++) begin
      enable_pulse();
      bif.btn = 4'b0100;
      watch(9, p, s);
      total += p;
      bif.btn = 4'b0000;
      watch(8, p, s);
      total += p;
    end
    chk("t6_pulses", 32'(total), 32'(nb));
    chk("t6_saturated", 32'(bif.voter_count), 255);

    // Reset on the edge that would enter EMIT suppresses the vote
    enable_pulse();
    bif.btn = 4'b0010;
    repeat (7) tick();
    chk("t7_pre_reset_v", 32'(vout()), 0);
    reset = 1'b1;
    tick();
    chk("t7_reset_v", 32'(vout()), 0);
    chk("t7_reset_busy", 32'(bif.busy), 0);
    chk("t7_reset_count", 32'(bif.voter_count), 0);
    reset = 1'b0;
    bif.btn = 4'b0000;
    watch(10, p, s);
    chk("t7_after_quiet", 32'(p), 0);

    // Reset during WAIT_RELEASE with the button still held
    enable_pulse();
    bif.btn = 4'b1000;
    watch(10, p, s);
    chk("t8_vote", 32'(s), 32'h8);
    chk("t8_wait_busy", 32'(bif.busy), 1);
    reset = 1'b1;
    tick();
    chk("t8_rst_v", 32'(vout()), 0);
    chk("t8_rst_ready", 32'(bif.ready), 0);
    chk("t8_rst_busy", 32'(bif.busy), 0);
    chk("t8_rst_flag", 32'(bif.timeout_flag), 0);
    chk("t8_rst_count", 32'(bif.voter_count), 0);
    reset = 1'b0;
    watch(12, p, s);
    chk("t8_locked_quiet", 32'(p), 0);
    enable_pulse();
    chk("t8_ready", 32'(bif.ready), 1);
    watch(15, p, s);
    chk("t8_held_no_vote", 32'(p), 0);
    chk("t8_count", 32'(bif.voter_count), 0);
    bif.btn = 4'b0000;
    watch(10, p, s);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
